// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the fetch PC and the in-order
//                imem request/response handshake, buffers up to two fetched
//                instructions ahead of IF/ID, and flushes the wrong path on
//                redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'hF000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] instruction,
  output logic [15:0] PC_out,
  output logic        instr_valid
);

  localparam int unsigned DEPTH = 2;

  // Fetch address and buffer bookkeeping
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;

  // In-flight request tracking; stale requests stay counted until they return
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  discard_q, discard_d;
  logic        tag_wr_q, tag_wr_d;
  logic        tag_rd_q, tag_rd_d;

  // Storage: instruction buffer and the PC tags of issued requests
  logic [15:0] buf_pc_q    [DEPTH];
  logic [15:0] buf_instr_q [DEPTH];
  logic [15:0] tag_q       [DEPTH];

  logic [1:0]  live;
  logic [2:0]  occupancy;
  logic        pop;
  logic        resp;
  logic        resp_write;
  logic        issue;

  // Requests whose responses will actually land in the buffer
  assign live      = outstanding_q - discard_q;
  assign occupancy = {1'b0, count_q} + {1'b0, live};

  // Head is consumed only when IF/ID is not stalled and no flush is happening
  assign pop = rst_n && !hazard && !redirect && (count_q != 2'd0);

  // A response with nothing outstanding is a protocol error and is ignored
  assign resp       = imem_valid && (outstanding_q != 2'd0);
  assign resp_write = resp && !redirect && (discard_q == 2'd0);

  // Only issue when the buffer is guaranteed a free slot for the response,
  // counting the slot freed by this cycle's pop
  assign issue = rst_n && !redirect && (outstanding_q < 2'd2) &&
                 ((occupancy - {2'b00, pop}) < 3'd2);

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

  // Present the head entry, or a NOP bubble when nothing valid is buffered
  assign instr_valid = rst_n && (count_q != 2'd0) && !redirect;
  assign instruction = instr_valid ? buf_instr_q[rd_ptr_q] : NOP_INSTR;
  assign PC_out      = instr_valid ? buf_pc_q[rd_ptr_q]    : 16'h0000;

  // Next-state computation; redirect overrides normal fetch/fill/consume
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;

    // Every returning response retires its tag, stale or not
    if (resp) begin
      tag_rd_d = ~tag_rd_q;
    end
    if (issue) begin
      tag_wr_d = ~tag_wr_q;
    end

    if (redirect) begin
      count_d       = 2'd0;
      wr_ptr_d      = 1'b0;
      rd_ptr_d      = 1'b0;
      fetch_pc_d    = redirect_pc;
      // Everything still in flight after this cycle belongs to the old path
      outstanding_d = outstanding_q - {1'b0, resp};
      discard_d     = outstanding_q - {1'b0, resp};
    end else begin
      count_d       = count_q + {1'b0, resp_write} - {1'b0, pop};
      outstanding_d = outstanding_q - {1'b0, resp} + {1'b0, issue};
      if (resp_write) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (resp && (discard_q != 2'd0)) begin
        discard_d = discard_q - 2'd1;
      end
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 16'd1;
      end
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      outstanding_q <= 2'd0;
      discard_q     <= 2'd0;
      tag_wr_q      <= 1'b0;
      tag_rd_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
    end
  end

  // Per-entry storage; data needs no reset since validity lives in count/pointers
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    // Capture a returned instruction with its tag PC, and record issued addresses
    always_ff @(posedge clk) begin
      if (rst_n && resp_write && (wr_ptr_q == 1'(i))) begin
        buf_pc_q[i]    <= tag_q[tag_rd_q];
        buf_instr_q[i] <= imem_data;
      end
      if (issue && (tag_wr_q == 1'(i))) begin
        tag_q[i] <= fetch_pc_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Scoreboard bench for fetch_unit with an in-order memory model
//                of configurable latency (data = addr | 16'hA000).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hazard;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [15:0] instruction;
  logic [15:0] PC_out;
  logic        instr_valid;

  exp_t  exp_q [$];
  mreq_t mem_q [$];
  int    mem_lat = 1;
  int    tcnt    = 0;
  int    n_cmp   = 0;
  int    n_err   = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hazard      (hazard),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .instruction (instruction),
    .PC_out      (PC_out),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] pc);
    exp_q.push_back({pc, pc | 16'hA000});
  endtask

  // Memory model: responds in order, mem_lat cycles after each request
  always @(posedge clk) begin
    tcnt = tcnt + 1;
    if (!rst_n) mem_q.delete();
    #1;
    if (mem_q.size() > 0 && mem_q[0].due == tcnt) begin
      imem_valid = 1'b1;
      imem_data  = mem_q[0].addr | 16'hA000;
      void'(mem_q.pop_front());
    end else begin
      imem_valid = 1'b0;
      imem_data  = 16'h0000;
    end
  end

  // Request capture, away from the clock edge
  always @(negedge clk) begin
    if (rst_n && imem_req) mem_q.push_back({imem_addr, 32'(tcnt + mem_lat)});
  end

  // Scoreboard monitor: compare each consumed instruction, and NOP when idle
  always @(negedge clk) begin
    exp_t e;
    if (instr_valid) begin
      if (!hazard && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_instr", 32'(instruction), 32'(e.instr));
        chk("sb_pc", 32'(PC_out), 32'(e.pc));
      end
    end else begin
      chk("nop_instr", 32'(instruction), 32'hF000);
      chk("nop_pc", 32'(PC_out), 32'h0000);
    end
  end

  // One reset cycle; leaves the caller at the start of the first cycle after it
  task automatic do_reset(input int lat);
    rst_n    = 1'b0;
    redirect = 1'b0;
    mem_lat  = lat;
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instruction), 32'hF000);
    chk("rst_pc", 32'(PC_out), 32'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; hazard = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_valid = 1'b0; imem_data = 16'h0000;
    @(posedge clk); #1;

    // Free run, 1-cycle memory
    do_reset(1);
    for (int p = 0; p < 8; p++) push_exp(16'(p));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr", 32'(imem_addr), 32'(c));
      chk("t1_valid", 32'(instr_valid), (c >= 2) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // Hazard held 4 cycles while head is PC 5
    do_reset(1);
    for (int p = 0; p < 10; p++) push_exp(16'(p));
    for (int c = 0; c < 16; c++) begin
      hazard = (c >= 7 && c <= 10);
      @(negedge clk);
      if (c >= 7 && c <= 10) begin
        chk("t2_hold_valid", 32'(instr_valid), 32'd1);
        chk("t2_hold_pc", 32'(PC_out), 32'h0005);
        chk("t2_hold_req", 32'(imem_req), 32'd0);
      end
      if (c == 11) begin
        chk("t2_resume_req", 32'(imem_req), 32'd1);
        chk("t2_resume_addr", 32'(imem_addr), 32'h0007);
      end
      @(posedge clk); #1;
    end
    hazard = 1'b0;
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3-cycle memory, redirect with two requests outstanding
    do_reset(3);
    push_exp(16'h0040);
    push_exp(16'h0041);
    for (int c = 0; c < 10; c++) begin
      redirect    = (c == 2);
      redirect_pc = 16'h0040;
      @(negedge clk);
      if (c >= 2 && c <= 7) chk("t3_stale_valid", 32'(instr_valid), 32'd0);
      if (c == 2 || c == 3) chk("t3_req_idle", 32'(imem_req), 32'd0);
      if (c == 4) begin
        chk("t3_req", 32'(imem_req), 32'd1);
        chk("t3_addr", 32'(imem_addr), 32'h0040);
      end
      if (c == 8) begin
        chk("t3_new_valid", 32'(instr_valid), 32'd1);
        chk("t3_new_pc", 32'(PC_out), 32'h0040);
      end
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // 2-cycle memory, redirect with a response in flight, then a second redirect
    do_reset(2);
    push_exp(16'h0000);
    push_exp(16'h0001);
    push_exp(16'h0200);
    push_exp(16'h0201);
    for (int c = 0; c < 12; c++) begin
      redirect    = (c == 5 || c == 6);
      redirect_pc = (c == 5) ? 16'h0100 : 16'h0200;
      @(negedge clk);
      if (c == 5) chk("t4_resp_same_cycle", 32'(imem_valid), 32'd1);
      if (c >= 5 && c <= 9) chk("t4_flush_valid", 32'(instr_valid), 32'd0);
      if (c == 5 || c == 6) chk("t4_req_idle", 32'(imem_req), 32'd0);
      if (c == 7) begin
        chk("t4_req", 32'(imem_req), 32'd1);
        chk("t4_addr0", 32'(imem_addr), 32'h0200);
      end
      if (c == 8) chk("t4_addr1", 32'(imem_addr), 32'h0201);
      if (c == 10) begin
        chk("t4_new_valid", 32'(instr_valid), 32'd1);
        chk("t4_new_pc", 32'(PC_out), 32'h0200);
      end
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // Address wrap across 16'hFFFF
    do_reset(1);
    push_exp(16'h0000);
    push_exp(16'hFFFE);
    push_exp(16'hFFFF);
    push_exp(16'h0000);
    for (int c = 0; c < 9; c++) begin
      redirect    = (c == 3);
      redirect_pc = 16'hFFFE;
      @(negedge clk);
      if (c == 3) begin
        chk("t5_redir_valid", 32'(instr_valid), 32'd0);
        chk("t5_redir_req", 32'(imem_req), 32'd0);
      end
      if (c == 4) chk("t5_addr_fffe", 32'(imem_addr), 32'hFFFE);
      if (c == 5) chk("t5_addr_ffff", 32'(imem_addr), 32'hFFFF);
      if (c == 6) begin
        chk("t5_addr_wrap", 32'(imem_addr), 32'h0000);
        chk("t5_pc_fffe", 32'(PC_out), 32'hFFFE);
      end
      if (c == 8) chk("t5_pc_wrap", 32'(PC_out), 32'h0000);
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // Fill the buffer under hazard, then reset mid-operation
    hazard = 1'b0;
    do_reset(2);
    hazard = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 3 || c == 4) begin
        chk("t6_hold_valid", 32'(instr_valid), 32'd1);
        chk("t6_hold_pc", 32'(PC_out), 32'h0000);
      end
      if (c == 4) chk("t6_full_req", 32'(imem_req), 32'd0);
      @(posedge clk); #1;
    end
    do_reset(2);
    hazard = 1'b0;
    push_exp(16'h0000);
    push_exp(16'h0001);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("t6_post_valid", 32'(instr_valid), 32'd0);
        chk("t6_post_instr", 32'(instruction), 32'hF000);
        chk("t6_post_req", 32'(imem_req), 32'd1);
        chk("t6_post_addr", 32'(imem_addr), 32'h0000);
      end
      if (c == 3 || c == 4) chk("t6_refill_valid", 32'(instr_valid), 32'd1);
      @(posedge clk); #1;
    end
    chk("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
